// File: rtl/vga_if.sv
// Display raster bundle: position, sync and blank from the timing generator to the renderers.
interface vga_if #(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
) ();
  logic [HCOUNT_WIDTH-1:0] hcount;
  logic [VCOUNT_WIDTH-1:0] vcount;
  logic                    hsync;
  logic                    vsync;
  logic                    blank;

  modport src (output hcount, vcount, hsync, vsync, blank);
  modport dst (input  hcount, vcount, hsync, vsync, blank);
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator: position, active-low syncs and blank, all registered together.
// Latency: sync/blank coherent with position (zero skew); no backpressure, free-runs from reset.
// VGA_CLK_DIV_EN: defined -> /4 pixel enable for a 100 MHz clk_in, undefined -> 25 MHz, advance every edge.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk_in,
  input  logic rst_n_in,
  vga_if.src   vga,
  output logic pix_en_out,
  output logic line_start_out,
  output logic frame_start_out
);
  localparam int HCOUNT_WIDTH = 11;
  localparam int VCOUNT_WIDTH = 10;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCOUNT_WIDTH-1:0] H_LAST       = HCOUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [HCOUNT_WIDTH-1:0] H_VIS        = HCOUNT_WIDTH'(H_ACTIVE);
  localparam logic [HCOUNT_WIDTH-1:0] H_SYNC_START = HCOUNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_WIDTH-1:0] H_SYNC_END   = HCOUNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_LAST       = VCOUNT_WIDTH'(V_TOTAL - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_VIS        = VCOUNT_WIDTH'(V_ACTIVE);
  localparam logic [VCOUNT_WIDTH-1:0] V_SYNC_START = VCOUNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_WIDTH-1:0] V_SYNC_END   = VCOUNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic                    pix_en_q;
  logic [HCOUNT_WIDTH-1:0] h_next;
  logic [VCOUNT_WIDTH-1:0] v_next;
  logic                    hsync_next;
  logic                    vsync_next;
  logic                    blank_next;

`ifdef VGA_CLK_DIV_EN
  logic [1:0] div_q;

  // pix_en is set on the same edge the divider reaches 3, so the two always coincide
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q    <= 2'd0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_q + 2'd1;
      pix_en_q <= (div_q == 2'd2);
    end
  end
`else
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pix_en_q <= 1'b0;
    end else begin
      pix_en_q <= 1'b1;
    end
  end
`endif

  // Terminal counts compare for equality so the counters never leave their ranges
  always_comb begin
    h_next = vga.hcount;
    v_next = vga.vcount;
    if (vga.hcount == H_LAST) begin
      h_next = '0;
      v_next = (vga.vcount == V_LAST) ? '0 : vga.vcount + VCOUNT_WIDTH'(1);
    end else begin
      h_next = vga.hcount + HCOUNT_WIDTH'(1);
    end
    hsync_next = !((h_next >= H_SYNC_START) && (h_next <= H_SYNC_END));
    vsync_next = !((v_next >= V_SYNC_START) && (v_next <= V_SYNC_END));
    blank_next = (h_next >= H_VIS) || (v_next >= V_VIS);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vga.hcount <= '0;
      vga.vcount <= '0;
      vga.hsync  <= 1'b1;
      vga.vsync  <= 1'b1;
      vga.blank  <= 1'b0;
    end else if (pix_en_q) begin
      vga.hcount <= h_next;
      vga.vcount <= v_next;
      vga.hsync  <= hsync_next;
      vga.vsync  <= vsync_next;
      vga.blank  <= blank_next;
    end
  end

  assign pix_en_out      = pix_en_q;
  assign line_start_out  = pix_en_q && (vga.hcount == '0);
  assign frame_start_out = line_start_out && (vga.vcount == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size raster plus a shrunken-geometry instance for frame-level events.
module tb_vga_timing_gen;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_if vga_b ();
  vga_if vga_s ();
  logic pe_b, ls_b, fs_b, pe_s, ls_s, fs_s;

  vga_timing_gen dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .vga(vga_b),
    .pix_en_out(pe_b), .line_start_out(ls_b), .frame_start_out(fs_b)
  );

  // 16 steps per line, 10 lines per frame, 160 steps per frame
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk_in(clk), .rst_n_in(rst_n), .vga(vga_s),
    .pix_en_out(pe_s), .line_start_out(ls_s), .frame_start_out(fs_s)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit win_en = 1'b0;
  int n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0;

  typedef struct {
    int steps;
    int h;
    int v;
    int hs;
    int vs;
    int bl;
  } vec_t;
  vec_t vecs[15];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int exp_steps(int c);
`ifdef VGA_CLK_DIV_EN
    return c / 4;
`else
    return (c >= 1) ? c - 1 : 0;
`endif
  endfunction

  function automatic int exp_pe(int c);
`ifdef VGA_CLK_DIV_EN
    return (c % 4 == 3) ? 1 : 0;
`else
    return (c >= 1) ? 1 : 0;
`endif
  endfunction

  function automatic logic [31:0] pack(int h, int v, int hs, int vs, int bl, int pe, int ls, int fs);
    logic [31:0] r;
    r = '0;
    r[26:16] = h[10:0];
    r[15:6]  = v[9:0];
    r[5] = hs[0]; r[4] = vs[0]; r[3] = bl[0];
    r[2] = pe[0]; r[1] = ls[0]; r[0] = fs[0];
    return r;
  endfunction

  // Reference raster derived directly from the step count and geometry
  function automatic logic [31:0] model(int s, int ha, int hf, int hsw, int hb,
                                        int va, int vf, int vsw, int vb, int pe);
    int ht, vt, h, v, hs, vs, bl;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    h  = s % ht;
    v  = (s / ht) % vt;
    hs = (h >= ha + hf && h < ha + hf + hsw) ? 0 : 1;
    vs = (v >= va + vf && v < va + vf + vsw) ? 0 : 1;
    bl = (h >= ha || v >= va) ? 1 : 0;
    return pack(h, v, hs, vs, bl, pe, (pe != 0 && h == 0) ? 1 : 0,
                (pe != 0 && h == 0 && v == 0) ? 1 : 0);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_b();
    return pack(int'(vga_b.hcount), int'(vga_b.vcount), int'(vga_b.hsync), int'(vga_b.vsync),
                int'(vga_b.blank), int'(pe_b), int'(ls_b), int'(fs_b));
  endfunction

  function automatic logic [31:0] act_s();
    return pack(int'(vga_s.hcount), int'(vga_s.vcount), int'(vga_s.hsync), int'(vga_s.vsync),
                int'(vga_s.blank), int'(pe_s), int'(ls_s), int'(fs_s));
  endfunction

  // Every cycle, both instances against the reference raster and enable pattern
  always @(negedge clk) begin
    check("cycle_full",  act_b(), model(exp_steps(cyc), 640, 16, 96, 48, 480, 10, 2, 33, exp_pe(cyc)));
    check("cycle_small", act_s(), model(exp_steps(cyc), 8, 2, 3, 3, 6, 1, 2, 1, exp_pe(cyc)));
    if (win_en) begin
      if (pe_b && !vga_b.hsync && vga_b.vcount == '0) n_hs++;
      if (exp_steps(cyc) < 320) begin
        if (fs_s) n_fs++;
        if (ls_s) n_ls++;
        if (pe_s && !vga_s.vsync) n_vs++;
      end
    end
  end

  task automatic wait_steps(int target);
    int n;
    n = 0;
    while (exp_steps(cyc) != target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL wait_steps: step %0d never reached, at %0d", target, exp_steps(cyc));
    end
  endtask

  task automatic run_vec(int i);
    wait_steps(vecs[i].steps);
    check($sformatf("vec%0d", i),
          pack(int'(vga_b.hcount), int'(vga_b.vcount), int'(vga_b.hsync), int'(vga_b.vsync),
               int'(vga_b.blank), 0, 0, 0),
          pack(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].bl, 0, 0, 0));
  endtask

  initial begin
    int n;
    vecs[0]  = '{0,    0,   0, 1, 1, 0};
    vecs[1]  = '{1,    1,   0, 1, 1, 0};
    vecs[2]  = '{639,  639, 0, 1, 1, 0};
    vecs[3]  = '{640,  640, 0, 1, 1, 1};
    vecs[4]  = '{655,  655, 0, 1, 1, 1};
    vecs[5]  = '{656,  656, 0, 0, 1, 1};
    vecs[6]  = '{751,  751, 0, 0, 1, 1};
    vecs[7]  = '{752,  752, 0, 1, 1, 1};
    vecs[8]  = '{799,  799, 0, 1, 1, 1};
    vecs[9]  = '{800,  0,   1, 1, 1, 0};
    vecs[10] = '{1599, 799, 1, 1, 1, 1};
    vecs[11] = '{1600, 0,   2, 1, 1, 0};
    vecs[12] = '{2300, 700, 2, 0, 1, 1};
    vecs[13] = '{0,    0,   0, 1, 1, 0};
    vecs[14] = '{300,  300, 0, 1, 1, 0};

    repeat (3) @(negedge clk);
    check("reset_full",  act_b(), pack(0, 0, 1, 1, 0, 0, 0, 0));
    check("reset_small", act_s(), pack(0, 0, 1, 1, 0, 0, 0, 0));

    win_en = 1'b1;
    rst_n  = 1'b1;
    n = 0;
    while (!pe_b && n < 16) begin
      @(negedge clk);
      n++;
    end
`ifdef VGA_CLK_DIV_EN
    check("first_pix_en_cycle", 32'(cyc), 32'd3);
`else
    check("first_pix_en_cycle", 32'(cyc), 32'd1);
`endif

    for (int i = 0; i <= 12; i++) run_vec(i);
    // small instance at step 2300: frame 14, step 60 -> line 3, pixel 12 (in hsync, blanked)
    check("small_at_2300",
          pack(int'(vga_s.hcount), int'(vga_s.vcount), int'(vga_s.hsync), int'(vga_s.vsync),
               int'(vga_s.blank), 0, 0, 0),
          pack(12, 3, 0, 1, 1, 0, 0, 0));
    win_en = 1'b0;
    check("hsync_low_steps_line0", 32'(n_hs), 32'd96);
    check("vsync_low_steps_2frames", 32'(n_vs), 32'd64);
    check("line_starts_2frames", 32'(n_ls), 32'd20);
    check("frame_starts_2frames", 32'(n_fs), 32'd2);

    // asynchronous reset mid-line / mid-frame, away from any clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_full",  act_b(), pack(0, 0, 1, 1, 0, 0, 0, 0));
    check("async_reset_small", act_s(), pack(0, 0, 1, 1, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(13);
    n = 0;
    while (!fs_b && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_after_reset", 32'(fs_b && fs_s), 32'd1);
    run_vec(14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
